// File: rtl/data_path_pkg.sv
// Shared widths, A-input select codes and opcode values for the accumulator datapath.
// Latency: n/a (constants only).
// Backpressure: n/a.
package data_path_pkg;

  localparam int DW = 8;
  localparam int AW = 5;

  // A-input mux select codes
  localparam logic [1:0] ASEL_ADD  = 2'b00;
  localparam logic [1:0] ASEL_IN   = 2'b01;
  localparam logic [1:0] ASEL_RAM  = 2'b10;
  localparam logic [1:0] ASEL_ZERO = 2'b11;

  // Opcodes carried in IR[7:5]
  localparam logic [2:0] OP_LOAD  = 3'b000;
  localparam logic [2:0] OP_STORE = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_SUB   = 3'b011;
  localparam logic [2:0] OP_INPUT = 3'b100;
  localparam logic [2:0] OP_JZ    = 3'b101;
  localparam logic [2:0] OP_JPOS  = 3'b110;
  localparam logic [2:0] OP_HALT  = 3'b111;

endpackage

// File: rtl/ram_32x8.sv
// Program/data RAM: synchronous write, asynchronous read, contents not reset.
// Latency: read is combinational; a write shows up on rd_dat after the writing edge.
// Backpressure: none; a write is accepted on every edge where wr_vld is high.
module ram_32x8
  import data_path_pkg::*;
(
  input  logic          clk,
  input  logic          wr_vld,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wr_dat,
  output logic [DW-1:0] rd_dat
);

  logic [DW-1:0] mem [2**AW];

  // Write port: store wr_dat at addr on the rising edge
  always_ff @(posedge clk) begin
    if (wr_vld) begin
      mem[addr] <= wr_dat;
    end
  end

  assign rd_dat = mem[addr];

endmodule

// File: rtl/data_path.sv
// Accumulator datapath: IR, PC, A, 32x8 RAM, address/PC/A-input muxes and add/sub unit.
// Latency: each register updates one edge after its strobe; all outputs are combinational.
// Backpressure: none; every strobe from the control FSM is honoured on the next edge.
module data_path
  import data_path_pkg::*;
(
  input  logic          clk,
  input  logic          clear,
  input  logic          IRload,
  input  logic          JMPmux,
  input  logic          PCload,
  input  logic          Meminst,
  input  logic          MemWr,
  input  logic [1:0]    Asel,
  input  logic          Aload,
  input  logic          Sub,
  input  logic [DW-1:0] in,
  output logic [DW-1:0] out,
  output logic [2:0]    IR75,
  output logic          Aeq0,
  output logic          Apos,
  output logic [AW-1:0] MeminstOut,
  output logic [DW-1:0] regAOut,
  output logic [DW-1:0] RAMout,
  output logic [AW-1:0] IR40
);

  logic [DW-1:0] ir_q, ir_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [DW-1:0] a_q,  a_d;
  logic [DW-1:0] ram_rd_dat;
  logic [DW-1:0] alu_res;
  logic [DW-1:0] a_mux;
  logic [AW-1:0] mem_addr;

  assign mem_addr = Meminst ? ir_q[AW-1:0] : pc_q;

  // Writes are gated by clear so an asynchronous reset also blocks a same-cycle store
  ram_32x8 u_ram (
    .clk    (clk),
    .wr_vld (MemWr & clear),
    .addr   (mem_addr),
    .wr_dat (a_q),
    .rd_dat (ram_rd_dat)
  );

  // Adder/subtractor and A-input select
  always_comb begin
    alu_res = Sub ? (a_q - ram_rd_dat) : (a_q + ram_rd_dat);
    a_mux   = '0;
    unique case (Asel)
      ASEL_ADD:  a_mux = alu_res;
      ASEL_IN:   a_mux = in;
      ASEL_RAM:  a_mux = ram_rd_dat;
      ASEL_ZERO: a_mux = '0;
      default:   a_mux = '0;
    endcase
  end

  // Next-state for IR, PC and A; each holds unless its load strobe is set
  always_comb begin
    ir_d = ir_q;
    pc_d = pc_q;
    a_d  = a_q;
    if (IRload) ir_d = ram_rd_dat;
    if (PCload) pc_d = JMPmux ? ir_q[AW-1:0] : pc_q + AW'(1);
    if (Aload)  a_d  = a_mux;
  end

  // Register bank with asynchronous active-low clear
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      ir_q <= '0;
      pc_q <= '0;
      a_q  <= '0;
    end else begin
      ir_q <= ir_d;
      pc_q <= pc_d;
      a_q  <= a_d;
    end
  end

  assign out        = a_q;
  assign regAOut    = a_q;
  assign Aeq0       = (a_q == '0);
  assign Apos       = ~a_q[DW-1];
  assign IR75       = ir_q[DW-1:DW-3];
  assign IR40       = ir_q[AW-1:0];
  assign MeminstOut = mem_addr;
  assign RAMout     = ram_rd_dat;

endmodule

// File: tb/tb_data_path.sv
// Directed self-checking bench for data_path with hand-computed expectations.
// Latency: inputs change 1 time unit after a rising edge; outputs sampled at the same point.
// Backpressure: n/a.
module tb_data_path;

  logic       clk = 1'b0;
  logic       clear;
  logic       IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub;
  logic [1:0] Asel;
  logic [7:0] in;
  logic [7:0] out, regAOut, RAMout;
  logic [2:0] IR75;
  logic [4:0] MeminstOut, IR40;
  logic       Aeq0, Apos;

  int n_cmp = 0;
  int n_err = 0;

  data_path dut (
    .clk        (clk),
    .clear      (clear),
    .IRload     (IRload),
    .JMPmux     (JMPmux),
    .PCload     (PCload),
    .Meminst    (Meminst),
    .MemWr      (MemWr),
    .Asel       (Asel),
    .Aload      (Aload),
    .Sub        (Sub),
    .in         (in),
    .out        (out),
    .IR75       (IR75),
    .Aeq0       (Aeq0),
    .Apos       (Apos),
    .MeminstOut (MeminstOut),
    .regAOut    (regAOut),
    .RAMout     (RAMout),
    .IR40       (IR40)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just past it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    IRload = 0; JMPmux = 0; PCload = 0; Meminst = 0;
    MemWr = 0; Aload = 0; Sub = 0; Asel = 2'b00; in = 8'h00;
  endtask

  // Load A from the external input
  task automatic load_a(input logic [7:0] v);
    idle();
    Asel = 2'b01; Aload = 1; in = v;
    step();
    idle();
  endtask

  initial begin
    logic [7:0] seq [4];
    seq[0] = 8'd4; seq[1] = 8'd7; seq[2] = 8'd2; seq[3] = 8'd3;

    idle();
    clear = 0;
    #3;
    chk("rst_out",   out,        32'h0);
    chk("rst_rega",  regAOut,    32'h0);
    chk("rst_ir75",  IR75,       32'h0);
    chk("rst_ir40",  IR40,       32'h0);
    chk("rst_aeq0",  Aeq0,       32'h1);
    chk("rst_apos",  Apos,       32'h1);
    chk("rst_addr",  MeminstOut, 32'h0);

    // Loads ignored while clear is low
    Asel = 2'b01; Aload = 1; in = 8'd9; PCload = 1;
    step();
    chk("rst_hold_a",  out,        32'h0);
    chk("rst_hold_pc", MeminstOut, 32'h0);
    idle();
    clear = 1;

    // Input path
    for (int i = 0; i < 4; i++) begin
      Asel = 2'b01; Aload = 1; in = seq[i];
      step();
      chk("in_out",  out,     32'(seq[i]));
      chk("in_rega", regAOut, 32'(seq[i]));
      chk("in_aeq0", Aeq0,    32'h0);
      chk("in_apos", Apos,    32'h1);
    end
    idle();

    // Store A=3 to mem[0] through IR40=0, then reload it from RAM
    Meminst = 1; MemWr = 1;
    step();
    MemWr = 0;
    chk("st_ramout", RAMout, 32'd3);
    Asel = 2'b11; Aload = 1;
    step();
    chk("st_zero", out, 32'h0);
    Asel = 2'b10;
    step();
    chk("ld_a", out, 32'd3);

    // Add/sub with mem[0]=3
    load_a(8'd7);
    Meminst = 1; Asel = 2'b00; Aload = 1; Sub = 0;
    step();
    chk("add", out, 32'd10);
    Sub = 1;
    step();
    chk("sub", out, 32'd7);
    load_a(8'd2);
    Meminst = 1; Asel = 2'b00; Aload = 1; Sub = 1;
    step();
    chk("sub_neg",  out,  32'hFF);
    chk("neg_apos", Apos, 32'h0);
    chk("neg_aeq0", Aeq0, 32'h0);

    // MemWr with Aload: RAM gets pre-edge A (FF), A gets new input; old data visible before edge
    idle();
    Meminst = 1; MemWr = 1; Aload = 1; Asel = 2'b01; in = 8'h11;
    #1;
    chk("same_cyc_old", RAMout, 32'd3);
    step();
    chk("wr_pre_a",  RAMout, 32'hFF);
    chk("wr_new_a",  out,    32'h11);

    // Fetch/jump: mem[0]=A5
    load_a(8'hA5);
    Meminst = 1; MemWr = 1;
    step();
    idle();
    IRload = 1; PCload = 1; JMPmux = 0;
    step();
    idle();
    chk("f_ir75", IR75,       32'h5);
    chk("f_ir40", IR40,       32'h5);
    chk("f_pc",   MeminstOut, 32'h1);
    JMPmux = 1;
    step();
    chk("jmp_ignored", MeminstOut, 32'h1);
    PCload = 1;
    step();
    idle();
    chk("jmp_pc", MeminstOut, 32'h5);

    // PC wrap 31 -> 0
    PCload = 1;
    for (int i = 0; i < 26; i++) step();
    chk("pc_31", MeminstOut, 32'd31);
    step();
    chk("pc_wrap", MeminstOut, 32'd0);
    idle();
    Asel = 2'b11; Aload = 1;
    step();
    chk("zero_a",    out,  32'h0);
    chk("zero_aeq0", Aeq0, 32'h1);
    chk("zero_apos", Apos, 32'h1);

    // Async reset mid-operation: A=7, PC=3, IR=A5
    load_a(8'd7);
    PCload = 1;
    step(); step(); step();
    idle();
    chk("pre_pc", MeminstOut, 32'd3);
    chk("pre_a",  out,        32'd7);
    MemWr = 1; Aload = 1; Asel = 2'b01; in = 8'h33;
    #2;
    clear = 0;
    #1;
    chk("ar_a",    out,        32'h0);
    chk("ar_pc",   MeminstOut, 32'h0);
    chk("ar_ir75", IR75,       32'h0);
    chk("ar_ir40", IR40,       32'h0);
    step();
    chk("ar_ram",  RAMout, 32'hA5);
    chk("ar_hold", out,    32'h0);
    idle();
    clear = 1;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
